// File: rtl/banked_sync_mem_pkg.sv
// Shared types and constants for the banked memory models.
package gateboy_mem_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_WAIT   = 2'd1,
    MEM_ACCESS = 2'd2
  } mem_state_t;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  // Bank register width; a single-bank memory still carries a 1-bit register.
  function automatic int unsigned bank_width(input int unsigned nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

endpackage

// File: rtl/banked_sync_mem_if.sv
// Request/acknowledge memory bus between a bus master and banked_sync_mem.
interface banked_sync_mem_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 13
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          ack;
  logic          busy;

  modport master (output req, we, addr, wr_data, input rd_data, ack, busy);
  modport slave  (input req, we, addr, wr_data, output rd_data, ack, busy);

endinterface

// File: rtl/banked_sync_mem_ram_core.sv
// Plain clocked single-port array with a registered read port; only the read register resets.
module sync_ram_core #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32768,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/banked_sync_mem.sv
// Banked synchronous RAM: handshake FSM, wait-state counter and MBC-style bank register
// in front of a single sync_ram_core.
module banked_sync_mem
  import gateboy_mem_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 13,
  parameter int unsigned NBANKS      = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ZERO_REMAP  = 0,
  parameter int unsigned RESET_BANK  = 0,
  localparam int unsigned BW         = bank_width(NBANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  banked_sync_mem_if.slave     bus,
  input  logic                 bank_we,
  input  logic [BW-1:0]        bank_wdata,
  output logic [BW-1:0]        bank
);

  localparam int unsigned DEPTH     = NBANKS * (2 ** AW);
  localparam int unsigned PAW       = $clog2(DEPTH);
  localparam int unsigned LAST_WAIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  mem_state_t    state;
  mem_state_t    state_nxt;
  wait_cnt_t     cnt;
  wait_cnt_t     cnt_nxt;
  logic          ack_nxt;
  logic          busy_nxt;
  logic          accept_c;
  logic          mem_we_c;
  logic          mem_re_c;

  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic [BW-1:0] cap_bank;
  logic [PAW-1:0] phys_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: begin
        if (bus.req) begin
          state_nxt = (WAIT_STATES > 0) ? MEM_WAIT : MEM_ACCESS;
        end
      end
      MEM_WAIT: begin
        if (cnt == WAIT_CNT_W'(LAST_WAIT)) begin
          state_nxt = MEM_ACCESS;
        end
      end
      MEM_ACCESS: state_nxt = MEM_IDLE;
      default:    state_nxt = MEM_IDLE;
    endcase
  end

  // Next-cycle values of the registered outputs and the array strobes for this cycle.
  always_comb begin
    cnt_nxt  = '0;
    accept_c = 1'b0;
    mem_we_c = 1'b0;
    mem_re_c = 1'b0;
    ack_nxt  = 1'b0;
    busy_nxt = (state_nxt != MEM_IDLE);
    case (state)
      MEM_IDLE:   accept_c = bus.req;
      MEM_WAIT:   cnt_nxt  = cnt + WAIT_CNT_W'(1);
      MEM_ACCESS: begin
        ack_nxt  = 1'b1;
        mem_we_c = cap_we;
        mem_re_c = !cap_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      bus.ack  <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      bus.ack  <= ack_nxt;
      bus.busy <= busy_nxt;
    end
  end

  // Captured request governs the whole access, including the bank seen at accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_we   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_bank <= '0;
    end else if (accept_c) begin
      cap_we   <= bus.we;
      cap_addr <= bus.addr;
      cap_data <= bus.wr_data;
      cap_bank <= bank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank <= (NBANKS > 1) ? BW'(RESET_BANK) : '0;
    end else if ((NBANKS > 1) && bank_we) begin
      bank <= ((ZERO_REMAP != 0) && (bank_wdata == '0)) ? BW'(1) : bank_wdata;
    end
  end

  // Single-bank builds drop the bank bit from the top of the concatenation.
  assign phys_addr = PAW'({cap_bank, cap_addr});

  sync_ram_core #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (mem_we_c && rst_n),
    .re      (mem_re_c && rst_n),
    .addr    (phys_addr),
    .wr_data (cap_data),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_banked_sync_mem.sv
// Scoreboard bench: two banked_sync_mem instances (no wait states / 3 wait states with bank-0 remap)
// checked against an associative-array memory model.
module tb_banked_sync_mem;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 13;
  localparam int unsigned NB   = 4;
  localparam int unsigned BW   = 2;
  localparam int unsigned WS_A = 0;
  localparam int unsigned WS_B = 3;
  localparam int unsigned RB_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banked_sync_mem_if #(.DW(DW), .AW(AW)) ia ();
  banked_sync_mem_if #(.DW(DW), .AW(AW)) ib ();

  logic          bwe_a, bwe_b;
  logic [BW-1:0] bwd_a, bwd_b, bank_a, bank_b;

  banked_sync_mem #(.DW(DW), .AW(AW), .NBANKS(NB), .WAIT_STATES(WS_A),
                    .ZERO_REMAP(0), .RESET_BANK(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave),
    .bank_we(bwe_a), .bank_wdata(bwd_a), .bank(bank_a));

  banked_sync_mem #(.DW(DW), .AW(AW), .NBANKS(NB), .WAIT_STATES(WS_B),
                    .ZERO_REMAP(1), .RESET_BANK(RB_B)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave),
    .bank_we(bwe_b), .bank_wdata(bwd_b), .bank(bank_b));

  typedef struct {
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int            s;
    logic [BW-1:0] bk;
    logic [AW-1:0] ad;
  } loc_t;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] mem_m [int];
  logic [BW-1:0] bank_m [2];
  logic [DW-1:0] last_m [2];
  exp_t          q_a[$];
  exp_t          q_b[$];
  loc_t          locs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] bank_next(input int s, input logic [BW-1:0] v);
    return (s == 1 && v == '0) ? BW'(1) : v;
  endfunction

  // Monitors: every ack must match an issued access; reads deliver model data, writes keep rd_data.
  always @(negedge clk) begin
    exp_t e;
    if (ia.ack) begin
      chk("a ack&busy", 32'(ia.busy), 32'd0);
      if (q_a.size() == 0) begin
        chk("a ack without accept", 32'(q_a.size()), 32'd1);
      end else begin
        e = q_a.pop_front();
        chk(e.rd ? "a read data" : "a rd_data hold", 32'(ia.rd_data), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ib.ack) begin
      chk("b ack&busy", 32'(ib.busy), 32'd0);
      if (q_b.size() == 0) begin
        chk("b ack without accept", 32'(q_b.size()), 32'd1);
      end else begin
        e = q_b.pop_front();
        chk(e.rd ? "b read data" : "b rd_data hold", 32'(ib.rd_data), 32'(e.data));
      end
    end
  end

  task automatic set_bank(input int s, input logic [BW-1:0] v);
    @(negedge clk);
    if (s == 0) begin bwe_a = 1'b1; bwd_a = v; end
    else        begin bwe_b = 1'b1; bwd_b = v; end
    bank_m[s] = bank_next(s, v);
    @(negedge clk);
    bwe_a = 1'b0;
    bwe_b = 1'b0;
    chk(s == 0 ? "a bank" : "b bank", 32'(s == 0 ? bank_a : bank_b), 32'(bank_m[s]));
  endtask

  // One access; chain: start at the current (ack) negedge, keep: leave req high afterwards.
  task automatic acc(input int s, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                     input bit chain, input bit keep, input bit bk, input logic [BW-1:0] bv);
    int   n;
    int   nb;
    int   ws;
    int   key;
    bit   ackd;
    bit   bsy;
    exp_t e;
    ws = (s == 0) ? WS_A : WS_B;
    if (!chain) @(negedge clk);
    key = s * 65536 + 32'({bank_m[s], ad});
    if (w) begin
      mem_m[key] = d;
      e = '{1'b0, last_m[s]};
    end else begin
      e = '{1'b1, mem_m[key]};
      last_m[s] = mem_m[key];
    end
    if (s == 0) begin
      q_a.push_back(e);
      ia.req = 1'b1; ia.we = w; ia.addr = ad; ia.wr_data = d; bwe_a = bk; bwd_a = bv;
    end else begin
      q_b.push_back(e);
      ib.req = 1'b1; ib.we = w; ib.addr = ad; ib.wr_data = d; bwe_b = bk; bwd_b = bv;
    end
    if (bk) bank_m[s] = bank_next(s, bv);
    @(posedge clk);
    n = 0;
    nb = 0;
    forever begin
      @(negedge clk);
      n++;
      bwe_a = 1'b0;
      bwe_b = 1'b0;
      ackd = (s == 0) ? ia.ack : ib.ack;
      bsy  = (s == 0) ? ia.busy : ib.busy;
      if (ackd) break;
      if (bsy) nb++;
      if (n > 40) begin
        chk("ack timeout", 32'(n), 32'(ws + 2));
        break;
      end
      // Scrambled request fields while busy must not affect the access.
      if (s == 0) begin
        ia.we = 1'($urandom); ia.addr = AW'($urandom); ia.wr_data = DW'($urandom);
      end else begin
        ib.we = 1'($urandom); ib.addr = AW'($urandom); ib.wr_data = DW'($urandom);
      end
    end
    chk(s == 0 ? "a ack latency" : "b ack latency", 32'(n), 32'(ws + 2));
    chk(s == 0 ? "a busy cycles" : "b busy cycles", 32'(nb), 32'(ws + 1));
    if (!keep) begin
      ia.req = 1'b0;
      ib.req = 1'b0;
    end
  endtask

  task automatic wr(input int s, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    acc(s, 1'b1, ad, d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input int s, input logic [AW-1:0] ad);
    acc(s, 1'b0, ad, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " a ack"}, 32'(ia.ack), 32'd0);
    chk({tag, " a busy"}, 32'(ia.busy), 32'd0);
    chk({tag, " a rd_data"}, 32'(ia.rd_data), 32'd0);
    chk({tag, " a bank"}, 32'(bank_a), 32'd0);
    chk({tag, " b ack"}, 32'(ib.ack), 32'd0);
    chk({tag, " b busy"}, 32'(ib.busy), 32'd0);
    chk({tag, " b rd_data"}, 32'(ib.rd_data), 32'd0);
    chk({tag, " b bank"}, 32'(bank_b), 32'(RB_B));
  endtask

  initial begin
    loc_t l;
    ia.req = 1'b0; ia.we = 1'b0; ia.addr = '0; ia.wr_data = '0;
    ib.req = 1'b0; ib.we = 1'b0; ib.addr = '0; ib.wr_data = '0;
    bwe_a = 1'b0; bwd_a = '0; bwe_b = 1'b0; bwd_b = '0;
    bank_m[0] = '0;
    bank_m[1] = BW'(RB_B);
    last_m[0] = '0;
    last_m[1] = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Basic write then read on both instances.
    wr(0, 13'h0010, 8'hA5);
    rd(0, 13'h0010);
    wr(1, 13'h0010, 8'h3C);
    rd(1, 13'h0010);

    // Same window address in different banks.
    for (int s = 0; s < 2; s++) begin
      set_bank(s, BW'(1));
      wr(s, 13'h0000, 8'h11);
      set_bank(s, BW'(2));
      wr(s, 13'h0000, 8'h22);
      set_bank(s, BW'(1));
      rd(s, 13'h0000);
      set_bank(s, BW'(2));
      rd(s, 13'h0000);
    end

    // Bank-0 remap, masking, and a bank load on the accept edge using the old bank.
    set_bank(1, BW'(0));
    set_bank(1, BW'(5));
    set_bank(1, BW'(3));
    acc(1, 1'b1, 13'h0020, 8'h77, 1'b0, 1'b0, 1'b1, BW'(0));
    chk("b bank after same-edge load", 32'(bank_b), 32'd1);
    wr(1, 13'h0020, 8'h66);
    set_bank(1, BW'(3));
    rd(1, 13'h0020);
    acc(0, 1'b1, 13'h0030, 8'h9C, 1'b0, 1'b0, 1'b1, BW'(3));
    set_bank(0, BW'(2));
    rd(0, 13'h0030);

    // Reset during WAIT drops the pending write.
    set_bank(1, BW'(RB_B));
    wr(1, 13'h0040, 8'h33);
    @(negedge clk);
    ib.req = 1'b1; ib.we = 1'b1; ib.addr = 13'h0040; ib.wr_data = 8'h5A;
    @(posedge clk);
    repeat (2) @(negedge clk);
    chk("b busy in wait", 32'(ib.busy), 32'd1);
    rst_n = 1'b0;
    ib.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bank_m[0] = '0;
    bank_m[1] = BW'(RB_B);
    last_m[0] = '0;
    last_m[1] = '0;
    check_reset_state("mid-access reset");
    repeat (6) @(negedge clk);
    chk("b no ack after reset", 32'(q_b.size()), 32'd0);
    rd(1, 13'h0040);

    // Back-to-back reads with req held high.
    wr(1, 13'h0041, 8'hC1);
    wr(1, 13'h0042, 8'hC2);
    acc(1, 1'b0, 13'h0040, '0, 1'b0, 1'b1, 1'b0, '0);
    acc(1, 1'b0, 13'h0041, '0, 1'b1, 1'b1, 1'b0, '0);
    acc(1, 1'b0, 13'h0042, '0, 1'b1, 1'b0, 1'b0, '0);
    set_bank(0, BW'(1));
    acc(0, 1'b0, 13'h0000, '0, 1'b0, 1'b1, 1'b0, '0);
    acc(0, 1'b0, 13'h0000, '0, 1'b1, 1'b1, 1'b0, '0);
    acc(0, 1'b1, 13'h0001, 8'h4D, 1'b1, 1'b1, 1'b0, '0);
    acc(0, 1'b0, 13'h0001, '0, 1'b1, 1'b0, 1'b0, '0);

    // Randomised writes across banks, then read everything back.
    for (int i = 0; i < 24; i++) begin
      l.s  = int'($urandom_range(0, 1));
      l.ad = AW'($urandom);
      if ($urandom_range(0, 2) == 0) set_bank(l.s, BW'($urandom));
      l.bk = bank_m[l.s];
      wr(l.s, l.ad, DW'($urandom));
      locs.push_back(l);
    end
    for (int i = 0; i < 24; i++) begin
      l = locs[$urandom_range(0, locs.size() - 1)];
      set_bank(l.s, l.bk);
      rd(l.s, l.ad);
    end

    repeat (4) @(negedge clk);
    chk("a scoreboard drained", 32'(q_a.size()), 32'd0);
    chk("b scoreboard drained", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
